// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, NOP constant and address-split width helpers
package icache_pkg;
  typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_DATA} state_e;
  localparam logic [31:0] NOP = 32'h00000013;
  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction
  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction
  function automatic int tag_w(input int line_words, input int num_lines);
    return 62 - $clog2(line_words) - $clog2(num_lines);
  endfunction
endpackage

// File: rtl/icache_tag_data_array.sv
// icache_tag_data_array: flop-based valid/tag/data store, combinational read, single sync write
module icache_tag_data_array
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES = 64,
  localparam int OW = off_w(LINE_WORDS),
  localparam int IW = idx_w(NUM_LINES),
  localparam int TW = tag_w(LINE_WORDS, NUM_LINES)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic [IW-1:0] rd_idx_i,
  input  logic [OW-1:0] rd_off_i,
  output logic          rd_valid_o,
  output logic [TW-1:0] rd_tag_o,
  output logic [31:0]   rd_data_o,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [OW-1:0] wr_off_i,
  input  logic [31:0]   wr_data_i,
  input  logic          line_en_i,
  input  logic          line_valid_i,
  input  logic [TW-1:0] wr_tag_i
);
  logic [NUM_LINES-1:0] valid_q;
  logic [TW-1:0]        tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_off_i];
  // flush beats a same-cycle line install so a flushed line never comes back valid
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_LINES; i++)
      if (rst_i || flush_i) valid_q[i] <= 1'b0;
      else if (line_en_i && wr_idx_i == IW'(i)) valid_q[i] <= line_valid_i;
  end
  always_ff @(posedge clk_i) begin
    if (wr_en_i) data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    if (line_en_i) tag_q[wr_idx_i] <= wr_tag_i;
  end
endmodule

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: direct-mapped icache with hit lookup and burst line-fill FSM
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int          LINE_WORDS = 4,
  parameter int          NUM_LINES  = 64,
  parameter logic [63:0] MEM_BYTES  = 64'h1_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [63:0] PC,
  output logic        icache_r,
  output logic [31:0] instruction,
  output logic        icache_fault,
  input  logic        flush,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int OW = off_w(LINE_WORDS);
  localparam int IW = idx_w(NUM_LINES);
  localparam int TW = tag_w(LINE_WORDS, NUM_LINES);
  localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);
  state_e        state_q, state_d;
  logic [63:0]   addr_q, addr_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic          poison_q, poison_d;
  logic          rd_valid, wr_en, line_en;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_data;
  assign icache_fault = PC >= MEM_BYTES;
  assign icache_r     = state_q == IDLE && rd_valid && rd_tag == PC[63-:TW] && !icache_fault;
  assign instruction  = icache_r ? rd_data : NOP;
  assign mem_req      = state_q == FILL_REQ;
  assign mem_addr     = addr_q;
  assign wr_en        = state_q == FILL_DATA && mem_rvalid;
  assign line_en      = wr_en && cnt_q == LAST;
  icache_tag_data_array #(.LINE_WORDS(LINE_WORDS), .NUM_LINES(NUM_LINES)) u_array (
    .clk_i(CLK), .rst_i(RESET), .flush_i(flush),
    .rd_idx_i(PC[OW+2+:IW]), .rd_off_i(PC[OW+1:2]),
    .rd_valid_o(rd_valid), .rd_tag_o(rd_tag), .rd_data_o(rd_data),
    .wr_en_i(wr_en), .wr_idx_i(addr_q[OW+2+:IW]), .wr_off_i(cnt_q), .wr_data_i(mem_rdata),
    .line_en_i(line_en), .line_valid_i(!(poison_q || flush)), .wr_tag_i(addr_q[63-:TW])
  );
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    poison_d = poison_q;
    unique case (state_q)
      IDLE: if (!icache_r && !icache_fault && !flush) begin
        state_d  = FILL_REQ;
        addr_d   = {PC[63:OW+2], (OW+2)'(0)};
        poison_d = 1'b0;
      end
      FILL_REQ: begin
        poison_d = poison_q || flush;
        if (mem_ack) begin
          state_d = FILL_DATA;
          cnt_d   = '0;
        end
      end
      FILL_DATA: begin
        poison_d = poison_q || flush;
        if (wr_en) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = cnt_q == LAST ? IDLE : FILL_DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      poison_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      poison_q <= poison_d;
    end
  end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: directed scenario tests for icache_fill_ctrl with hand-computed expectations
module tb_icache_fill_ctrl;
  localparam logic [31:0] NOP_I = 32'h00000013;
  logic        CLK = 1'b0, RESET = 1'b1, flush = 1'b0, mem_ack = 1'b0, mem_rvalid = 1'b0;
  logic [63:0] PC = '0;
  logic [31:0] mem_rdata = '0;
  logic        icache_r, icache_fault, mem_req;
  logic [31:0] instruction;
  logic [63:0] mem_addr;
  int tests = 0, errors = 0;

  icache_fill_ctrl dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .icache_r(icache_r), .instruction(instruction),
    .icache_fault(icache_fault), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_hit(input string nm, input logic [63:0] pc, input logic [31:0] exp);
    PC = pc;
    #1;
    tests++;
    if (icache_r !== 1'b1 || instruction !== exp) begin
      errors++;
      $display("FAIL %s: icache_r=%0b instruction=%h, expected icache_r=1 instruction=%h", nm, icache_r, instruction, exp);
    end
  endtask

  task automatic expect_miss(input string nm, input logic [63:0] pc);
    PC = pc;
    #1;
    tests++;
    if (icache_r !== 1'b0 || instruction !== NOP_I) begin
      errors++;
      $display("FAIL %s: icache_r=%0b instruction=%h, expected icache_r=0 instruction=%h", nm, icache_r, instruction, NOP_I);
    end
  endtask

  task automatic expect_req(input string nm, input logic [63:0] addr);
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== addr) begin
      errors++;
      $display("FAIL %s: mem_req=%0b mem_addr=%h, expected mem_req=1 mem_addr=%h", nm, mem_req, mem_addr, addr);
    end
  endtask

  // caller is in FILL_REQ; ack one cycle then four ascending beats
  task automatic fill(input logic [31:0] base, input int flush_beat);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    tests++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL req_drop: mem_req=%0b expected 0", mem_req);
    end
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(i);
      flush      = (i == flush_beat);
      #1;
      tests++;
      if (icache_r !== 1'b0) begin
        errors++;
        $display("FAIL busy_no_hit: icache_r=%0b expected 0 at beat %0d", icache_r, i);
      end
      step();
    end
    mem_rvalid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    #1;
    tests++;
    if (icache_r !== 1'b0 || instruction !== NOP_I || mem_req !== 1'b0 || mem_addr !== 64'h0 || icache_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset: r=%0b instr=%h req=%0b addr=%h fault=%0b, expected 0/%h/0/0/0",
               icache_r, instruction, mem_req, mem_addr, icache_fault, NOP_I);
    end
  endtask

  task automatic test_cold_miss();
    expect_miss("cold_miss", 64'h40);
    step();
    expect_req("cold_req", 64'h40);
    fill(32'hA0, -1);
    expect_hit("cold_hit_w0", 64'h40, 32'hA0);
    expect_hit("cold_hit_w3", 64'h4C, 32'hA3);
    expect_hit("cold_hit_w1", 64'h45, 32'hA1);
  endtask

  task automatic test_conflict();
    expect_miss("conflict_miss", 64'h440);
    step();
    expect_req("conflict_req", 64'h440);
    fill(32'hB0, -1);
    expect_hit("conflict_hit", 64'h448, 32'hB2);
    expect_miss("conflict_evicted", 64'h40);
    step();
    expect_req("conflict_refill_req", 64'h40);
    fill(32'hA0, -1);
    expect_hit("conflict_refill_hit", 64'h40, 32'hA0);
  endtask

  task automatic test_flush_mid_fill();
    expect_miss("flush_miss", 64'h80);
    step();
    expect_req("flush_req", 64'h80);
    fill(32'hC0, 1);
    expect_miss("flush_poisoned", 64'h80);
    step();
    expect_req("flush_refetch_req", 64'h80);
    fill(32'hC0, -1);
    expect_hit("flush_refill_hit", 64'h84, 32'hC1);
    expect_miss("flush_cleared_other", 64'h40);
  endtask

  task automatic test_fault();
    PC = 64'h1_0000;
    #1;
    tests++;
    if (icache_fault !== 1'b1 || icache_r !== 1'b0 || instruction !== NOP_I) begin
      errors++;
      $display("FAIL fault: fault=%0b r=%0b instr=%h, expected 1/0/%h", icache_fault, icache_r, instruction, NOP_I);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    tests++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fault_no_req: mem_req=%0b expected 0", mem_req);
    end
    PC = 64'hFFFC;
    #1;
    tests++;
    if (icache_fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_boundary: fault=%0b expected 0 at PC=FFFC", icache_fault);
    end
  endtask

  task automatic test_ack_delay();
    expect_miss("delay_miss", 64'h40);
    step();
    PC = 64'h80;
    for (int i = 0; i < 5; i++) begin
      #1;
      expect_req("delay_hold", 64'h40);
      step();
    end
    fill(32'hD0, -1);
    expect_miss("delay_second_miss", 64'h80);
    step();
    expect_req("delay_second_req", 64'h80);
    fill(32'hE0, -1);
    expect_hit("delay_hit_80", 64'h80, 32'hE0);
    expect_hit("delay_hit_44", 64'h44, 32'hD1);
  endtask

  task automatic test_reset_mid_fill();
    expect_hit("rst_prehit", 64'h40, 32'hD0);
    PC = 64'h440;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11;
    step();
    RESET     = 1'b1;
    mem_rdata = 32'h22;
    step();
    RESET     = 1'b0;
    mem_rdata = 32'h33;
    tests++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_req: mem_req=%0b expected 0", mem_req);
    end
    expect_miss("rst_mid_invalid", 64'h40);
    step();
    expect_req("rst_refill_req", 64'h40);
    mem_rdata = 32'hDEAD;
    step();
    mem_rvalid = 1'b0;
    fill(32'hF0, -1);
    expect_hit("rst_refill_hit0", 64'h40, 32'hF0);
    expect_hit("rst_refill_hit3", 64'h4C, 32'hF3);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_flush_mid_fill();
    test_fault();
    test_ack_delay();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
